prg_loader: RTL and testbench

//  Sits between the SPI downloader and the RAM write mux of the Apple-1 top level.

---
 rtl/prg_loader.sv | 205 ++++++++++++++++++++
 tb/tb_prg_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prg_loader.sv
// prg_loader: parses a downloaded .PRG image (2-byte little-endian load address, then payload)
// and relocates the payload into CPU RAM, holding each write for WR_STRETCH cycles.
module prg_loader #(
  parameter logic [15:0] RAM_TOP    = 16'hBFFF,
  parameter int unsigned WR_STRETCH = 1
) (
  input  logic        clk14,
  input  logic        rst_n,
  input  logic        dl_active,
  input  logic        dl_is_prg,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wr,
  output logic        busy,
  output logic [15:0] load_start,
  output logic [15:0] load_end,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] CNT_INIT = 2'(WR_STRETCH - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_FIN} state_t;

  state_t      state_q, state_d;
  logic        act_q;
  logic [15:0] start_q, start_d;
  logic [15:0] end_q, end_d;
  logic [15:0] wptr_q, wptr_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_data_q, mem_data_d;
  logic        mem_wr_q, mem_wr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        skid_vld_q, skid_vld_d;
  logic [15:0] skid_addr_q, skid_addr_d;
  logic [7:0]  skid_data_q, skid_data_d;

  logic        rise, eng_free, wr_ok, push, carry;
  logic [15:0] wptr_inc;

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    end_d       = end_q;
    wptr_d      = wptr_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_wr_d    = mem_wr_q;
    cnt_d       = cnt_q;
    skid_vld_d  = skid_vld_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    push        = 1'b0;

    rise              = dl_active & ~act_q;
    {carry, wptr_inc} = {1'b0, wptr_q} + 17'd1;
    wr_ok             = (wptr_q <= RAM_TOP) && !ovf_q;

    // cnt_q counts the remaining high cycles after the current one
    if (mem_wr_q) begin
      if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
      else               mem_wr_d = 1'b0;
    end
    eng_free = !mem_wr_q || (cnt_q == 2'd0);

    if (rise && state_q != S_IDLE) begin
      err_d   = 1'b1;
      ovf_d   = 1'b0;
      state_d = S_HDR_LO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise && dl_is_prg) begin
            state_d = S_HDR_LO;
            err_d   = 1'b0;
            end_d   = 16'h0000;
            start_d = 16'h0000;
            ovf_d   = 1'b0;
          end
        end
        S_HDR_LO: begin
          if (!dl_active) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (dl_wr) begin
            start_d[7:0] = dl_data;
            busy_d       = 1'b1;
            state_d      = S_HDR_HI;
          end
        end
        S_HDR_HI: begin
          if (!dl_active) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (dl_wr) begin
            start_d[15:8] = dl_data;
            wptr_d        = {dl_data, start_q[7:0]};
            end_d         = {dl_data, start_q[7:0]};
            state_d       = S_DATA;
          end
        end
        S_DATA: begin
          if (dl_wr) begin
            wptr_d = wptr_inc;
            if (carry) ovf_d = 1'b1;
            if (wr_ok) push = 1'b1;
            else       err_d = 1'b1;
          end
          if (!dl_active && !dl_wr && !mem_wr_q && !skid_vld_q) state_d = S_FIN;
        end
        S_FIN: begin
          busy_d  = 1'b0;
          done_d  = !err_q;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // write engine: the skid entry always goes before a newly arrived byte
    if (eng_free && skid_vld_q) begin
      mem_wr_d   = 1'b1;
      cnt_d      = CNT_INIT;
      mem_addr_d = skid_addr_q;
      mem_data_d = skid_data_q;
      skid_vld_d = push;
      if (push) begin
        skid_addr_d = wptr_q;
        skid_data_d = dl_data;
        end_d       = wptr_q;
      end
    end else if (eng_free && push) begin
      mem_wr_d   = 1'b1;
      cnt_d      = CNT_INIT;
      mem_addr_d = wptr_q;
      mem_data_d = dl_data;
      end_d      = wptr_q;
    end else if (push && !skid_vld_q) begin
      skid_vld_d  = 1'b1;
      skid_addr_d = wptr_q;
      skid_data_d = dl_data;
      end_d       = wptr_q;
    end else if (push) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      act_q       <= 1'b0;
      start_q     <= 16'h0000;
      end_q       <= 16'h0000;
      wptr_q      <= 16'h0000;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_data_q  <= 8'h00;
      mem_wr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      skid_vld_q  <= 1'b0;
      skid_addr_q <= 16'h0000;
      skid_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      act_q       <= dl_active;
      start_q     <= start_d;
      end_q       <= end_d;
      wptr_q      <= wptr_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_wr_q    <= mem_wr_d;
      cnt_q       <= cnt_d;
      skid_vld_q  <= skid_vld_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_wr     = mem_wr_q;
  assign busy       = busy_q;
  assign load_start = start_q;
  assign load_end   = end_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prg_loader.sv
// Bench for prg_loader: two instances (stretch 1 and 3) share stimulus; a negedge monitor
// pops expected {addr,data} writes from per-instance queues.
`timescale 1ns/1ps
module tb_prg_loader;

  logic       clk14 = 1'b0;
  logic       rst_n = 1'b0;
  logic       dl_active = 1'b0, dl_is_prg = 1'b0, dl_wr = 1'b0;
  logic [7:0] dl_data = 8'h00;

  logic [15:0] mem_addr [2];
  logic [7:0]  mem_data [2];
  logic        mem_wr   [2];
  logic        busy     [2];
  logic [15:0] load_start [2];
  logic [15:0] load_end [2];
  logic        done     [2];
  logic        err      [2];

  prg_loader #(.RAM_TOP(16'hBFFF), .WR_STRETCH(1)) u_dut0 (
    .clk14(clk14), .rst_n(rst_n), .dl_active(dl_active), .dl_is_prg(dl_is_prg),
    .dl_wr(dl_wr), .dl_data(dl_data), .mem_addr(mem_addr[0]), .mem_data(mem_data[0]),
    .mem_wr(mem_wr[0]), .busy(busy[0]), .load_start(load_start[0]), .load_end(load_end[0]),
    .done(done[0]), .err(err[0]));

  prg_loader #(.RAM_TOP(16'hBFFF), .WR_STRETCH(3)) u_dut1 (
    .clk14(clk14), .rst_n(rst_n), .dl_active(dl_active), .dl_is_prg(dl_is_prg),
    .dl_wr(dl_wr), .dl_data(dl_data), .mem_addr(mem_addr[1]), .mem_data(mem_data[1]),
    .mem_wr(mem_wr[1]), .busy(busy[1]), .load_start(load_start[1]), .load_end(load_end[1]),
    .done(done[1]), .err(err[1]));

  always #5 clk14 = ~clk14;

  int          n_chk = 0;
  int          n_err = 0;
  logic [23:0] q0[$];
  logic [23:0] q1[$];
  logic [23:0] cur [2];
  int          hold [2] = '{0, 0};
  logic        prev [2] = '{1'b0, 1'b0};
  int          done_cnt [2] = '{0, 0};
  logic        busy_seen [2] = '{1'b0, 1'b0};
  int          exp_done = 0;

  function automatic int str_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // monitor: one pop per write, address/data held stable, length == stretch
  always @(negedge clk14) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        hold[k] = 0;
        prev[k] = 1'b0;
      end else begin
        if (done[k]) done_cnt[k]++;
        if (busy[k]) busy_seen[k] = 1'b1;
        if (mem_wr[k] && (!prev[k] || hold[k] == str_of(k))) begin
          n_chk++;
          if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            n_err++;
            $display("FAIL wr_unexpected dut%0d: got %h=%h, required no write", k, mem_addr[k], mem_data[k]);
            cur[k] = {mem_addr[k], mem_data[k]};
          end else begin
            cur[k] = (k == 0) ? q0.pop_front() : q1.pop_front();
            if ({mem_addr[k], mem_data[k]} !== cur[k]) begin
              n_err++;
              $display("FAIL wr_data dut%0d: got %h=%h, required %h=%h", k, mem_addr[k], mem_data[k],
                       cur[k][23:8], cur[k][7:0]);
            end
          end
          hold[k] = 1;
        end else if (mem_wr[k]) begin
          hold[k]++;
          n_chk++;
          if ({mem_addr[k], mem_data[k]} !== cur[k]) begin
            n_err++;
            $display("FAIL wr_stable dut%0d: got %h=%h, required %h", k, mem_addr[k], mem_data[k], cur[k]);
          end
        end else if (prev[k]) begin
          n_chk++;
          if (hold[k] != str_of(k)) begin
            n_err++;
            $display("FAIL wr_len dut%0d: got %0d cycles, required %0d", k, hold[k], str_of(k));
          end
        end
        prev[k] = mem_wr[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk14);
    #1;
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
    q0.push_back({a, d});
    q1.push_back({a, d});
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    tick();
    dl_wr = 1'b1;
    dl_data = b;
    tick();
    dl_wr = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic start_dl(input logic prg);
    tick();
    dl_active = 1'b1;
    dl_is_prg = prg;
    tick();
  endtask

  task automatic end_dl();
    tick();
    dl_active = 1'b0;
    repeat (12) tick();
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic chk_result(input string tag, input logic [15:0] ls, input logic [15:0] le,
                            input logic e);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_start%0d", tag, k), 64'(load_start[k]), 64'(ls));
      chk($sformatf("%s_end%0d", tag, k), 64'(load_end[k]), 64'(le));
      chk($sformatf("%s_err%0d", tag, k), 64'(err[k]), 64'(e));
      chk($sformatf("%s_busy%0d", tag, k), 64'(busy[k]), 64'd0);
      chk($sformatf("%s_done%0d", tag, k), 64'(done_cnt[k]), 64'(exp_done));
    end
    chk($sformatf("%s_drain", tag), 64'(q0.size() + q1.size()), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 2; k++)
      chk($sformatf("%s%0d", tag, k),
          64'({mem_addr[k], mem_data[k], mem_wr[k], busy[k], load_start[k], load_end[k], done[k], err[k]}),
          64'd0);
  endtask

  logic [7:0] burst [4];

  initial begin
    repeat (2) tick();
    chk_zero("reset_state");
    rst_n = 1'b1;
    tick();

    // 1: basic relocation
    start_dl(1'b1);
    send(8'h00, 3);
    send(8'h03, 3);
    for (int k = 0; k < 2; k++) chk($sformatf("t1_busy%0d", k), 64'(busy[k]), 64'd1);
    exp_wr(16'h0300, 8'hA9); send(8'hA9, 3);
    exp_wr(16'h0301, 8'h01); send(8'h01, 3);
    exp_wr(16'h0302, 8'h60); send(8'h60, 3);
    end_dl();
    exp_done++;
    chk_result("t1", 16'h0300, 16'h0302, 1'b0);

    // 2: payload crosses RAM_TOP
    start_dl(1'b1);
    send(8'hFE, 3);
    send(8'hBF, 3);
    exp_wr(16'hBFFE, 8'h11); send(8'h11, 3);
    exp_wr(16'hBFFF, 8'h22); send(8'h22, 3);
    send(8'h33, 3);
    send(8'h44, 3);
    end_dl();
    chk_result("t2", 16'hBFFE, 16'hBFFF, 1'b1);

    // 3: truncated header
    start_dl(1'b1);
    send(8'h00, 3);
    end_dl();
    chk_result("t3", 16'h0000, 16'h0000, 1'b1);

    // 5: non-PRG download is ignored
    busy_seen[0] = 1'b0;
    busy_seen[1] = 1'b0;
    start_dl(1'b0);
    for (int i = 0; i < 256; i++) send(8'(i), 0);
    end_dl();
    for (int k = 0; k < 2; k++) chk($sformatf("t5_busy_seen%0d", k), 64'(busy_seen[k]), 64'd0);
    chk_result("t5", 16'h0000, 16'h0000, 1'b1);

    // 4: back-to-back strobes exercise the skid entry
    burst[0] = 8'h00; burst[1] = 8'h10; burst[2] = 8'h5A; burst[3] = 8'hA5;
    exp_wr(16'h1000, 8'h5A);
    exp_wr(16'h1001, 8'hA5);
    start_dl(1'b1);
    tick();
    dl_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dl_data = burst[i];
      tick();
    end
    dl_wr = 1'b0;
    end_dl();
    exp_done++;
    chk_result("t4", 16'h1000, 16'h1001, 1'b0);

    // 6: reset in the middle of a load, then a clean reload
    start_dl(1'b1);
    send(8'h00, 3);
    send(8'h20, 3);
    for (int i = 0; i < 10; i++) begin
      exp_wr(16'h2000 + 16'(i), 8'h30 + 8'(i));
      send(8'h30 + 8'(i), (i == 9) ? 0 : 3);
    end
    tick();
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async_zero");
    exp_done = 0;
    dl_active = 1'b0;
    dl_is_prg = 1'b0;
    repeat (2) tick();
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    rst_n = 1'b1;
    tick();
    start_dl(1'b1);
    send(8'h00, 3);
    send(8'h04, 3);
    exp_wr(16'h0400, 8'hDE); send(8'hDE, 3);
    exp_wr(16'h0401, 8'hAD); send(8'hAD, 3);
    end_dl();
    exp_done++;
    chk_result("t6", 16'h0400, 16'h0401, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
